// File: rtl/led_matrix_tx.sv
// Two-wire (DIN/SCLK) serial driver for the PMOD1A LED-matrix controller.
// Optional: define LEDTX_DONE_PULSE_EN to add a one-cycle o_done pulse when o_busy falls.
module led_matrix_tx #(
  parameter int unsigned CLK_DIV      = 6,
  parameter logic [7:0]  CMD_ONLY_POS = 8'hFF
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       i_valid,
  input  logic [7:0] i_pos,
  input  logic [7:0] i_value,
  output logic       o_din,
  output logic       o_sclk,
`ifdef LEDTX_DONE_PULSE_EN
  output logic       o_done,
`endif
  output logic       o_busy
);

  typedef enum logic [2:0] {
    StIdle, StStart, StBitLo, StBitHi, StStopLo, StStopHi, StEnd
  } state_e;

  localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  bit_q, bit_d;
  logic        two_q, two_d;
  logic        din_q, din_d;
  logic        sclk_q, sclk_d;
  logic        busy_q, busy_d;
  logic        phase_end;
  logic        req_two;
  logic [3:0]  last_bit;
`ifdef LEDTX_DONE_PULSE_EN
  logic        done_q, done_d;
`endif

  assign phase_end = (cnt_q == DivLast);
  assign req_two   = (i_pos != CMD_ONLY_POS);
  assign last_bit  = two_q ? 4'd15 : 4'd7;

  always_comb begin
    state_d = state_q;
    cnt_d   = phase_end ? 16'd0 : cnt_q + 16'd1;
    sr_d    = sr_q;
    bit_d   = bit_q;
    two_d   = two_q;
    din_d   = din_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
`ifdef LEDTX_DONE_PULSE_EN
    done_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = 16'd0;
        if (i_valid && !busy_q) begin
          state_d = StStart;
          busy_d  = 1'b1;
          din_d   = 1'b0;
          sclk_d  = 1'b1;
          two_d   = req_two;
          bit_d   = 4'd0;
          // Two-byte frames shift out pos first, so it occupies the low byte.
          sr_d    = req_two ? {i_value, i_pos} : {8'h00, i_value};
        end
      end
      StStart: begin
        if (phase_end) begin
          state_d = StBitLo;
          sclk_d  = 1'b0;
          din_d   = sr_q[0];
        end
      end
      StBitLo: begin
        if (phase_end) begin
          state_d = StBitHi;
          sclk_d  = 1'b1;
        end
      end
      StBitHi: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          if (bit_q == last_bit) begin
            state_d = StStopLo;
            din_d   = 1'b0;
          end else begin
            state_d = StBitLo;
            din_d   = sr_q[1];
            sr_d    = sr_q >> 1;
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      StStopLo: begin
        if (phase_end) begin
          state_d = StStopHi;
          sclk_d  = 1'b1;
        end
      end
      StStopHi: begin
        if (phase_end) begin
          state_d = StEnd;
          din_d   = 1'b1;
        end
      end
      StEnd: begin
        if (phase_end) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          bit_d   = 4'd0;
`ifdef LEDTX_DONE_PULSE_EN
          done_d  = 1'b1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 16'd0;
        din_d   = 1'b1;
        sclk_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      sr_q    <= 16'd0;
      bit_q   <= 4'd0;
      two_q   <= 1'b0;
      din_q   <= 1'b1;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
`ifdef LEDTX_DONE_PULSE_EN
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      two_q   <= two_d;
      din_q   <= din_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
`ifdef LEDTX_DONE_PULSE_EN
      done_q  <= done_d;
`endif
    end
  end

  assign o_din  = din_q;
  assign o_sclk = sclk_q;
  assign o_busy = busy_q;
`ifdef LEDTX_DONE_PULSE_EN
  assign o_done = done_q;
`endif

endmodule

// File: tb/tb_led_matrix_tx.sv
// Randomized bench for led_matrix_tx: per-cycle line waveform plus decoded-bit checks.
module tb_led_matrix_tx;

`ifdef LEDTX_DONE_PULSE_EN
  localparam int unsigned Div     = 3;
  localparam logic        DoneExp = 1'b1;
`else
  localparam int unsigned Div     = 2;
  localparam logic        DoneExp = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_pos = 8'h00;
  logic [7:0] i_value = 8'h00;
  logic       o_din, o_sclk, o_busy;
`ifdef LEDTX_DONE_PULSE_EN
  logic       o_done;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 CLK = ~CLK;

  led_matrix_tx #(
    .CLK_DIV      (Div),
    .CMD_ONLY_POS (8'hFF)
  ) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .i_valid (i_valid),
    .i_pos   (i_pos),
    .i_value (i_value),
    .o_din   (o_din),
    .o_sclk  (o_sclk),
`ifdef LEDTX_DONE_PULSE_EN
    .o_done  (o_done),
`endif
    .o_busy  (o_busy)
  );

  // {done, busy, sclk, din}
  function automatic logic [3:0] lines();
`ifdef LEDTX_DONE_PULSE_EN
    return {o_done, o_busy, o_sclk, o_din};
`else
    return {1'b0, o_busy, o_sclk, o_din};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge; the request is driven immediately.
  task automatic send_frame(input logic [7:0] pos, input logic [7:0] value,
                            input bit pulse_extra, input int abort_at);
    logic [7:0] bytes[$];
    logic [1:0] phases[$];
    logic [3:0] wave[$];
    logic       exp_bits[$];
    logic       got_bits[$];
    logic       prev_sclk;
    logic       b;

    if (pos == 8'hFF) bytes.push_back(value);
    else begin
      bytes.push_back(pos);
      bytes.push_back(value);
    end
    phases.push_back(2'b10);                      // start: sclk high, din low
    foreach (bytes[k]) begin
      for (int i = 0; i < 8; i++) begin
        b = bytes[k][i];
        exp_bits.push_back(b);
        phases.push_back({1'b0, b});
        phases.push_back({1'b1, b});
      end
    end
    phases.push_back(2'b00);
    phases.push_back(2'b10);
    phases.push_back(2'b11);
    foreach (phases[p]) for (int r = 0; r < int'(Div); r++) wave.push_back({2'b01, phases[p]});

    i_pos   = pos;
    i_value = value;
    i_valid = 1'b1;
    @(posedge CLK); #1;
    i_valid = 1'b0;
    prev_sclk = 1'b1;

    for (int c = 0; c < wave.size(); c++) begin
      if (c == abort_at) begin
        RSTN = 1'b0;
        #1;
        check("async_reset", 32'(lines()), 32'h3);
        @(posedge CLK); #1;
        RSTN = 1'b1;
        @(posedge CLK); #1;
        check("post_reset_idle", 32'(lines()), 32'h3);
        return;
      end
      check($sformatf("wave[%0d] pos=%0h val=%0h", c, pos, value), 32'(lines()), 32'(wave[c]));
      if (o_sclk && !prev_sclk) got_bits.push_back(o_din);
      prev_sclk = o_sclk;
      if (pulse_extra && (c == 3 || c == 20)) begin
        i_valid = 1'b1;
        i_pos   = 8'($urandom);
        i_value = 8'($urandom);
      end else begin
        i_valid = 1'b0;
      end
      @(posedge CLK); #1;
    end
    i_valid = 1'b0;
    check("end_idle", 32'(lines()), 32'({DoneExp, 3'b011}));
    check("sclk_rises", 32'(got_bits.size()), 32'(exp_bits.size() + 1));
    foreach (exp_bits[i])
      if (i < got_bits.size())
        check($sformatf("bit[%0d] pos=%0h val=%0h", i, pos, value), 32'(got_bits[i]),
              32'(exp_bits[i]));
  endtask

  initial begin
    logic [7:0] p;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_lines", 32'(lines()), 32'h3);
    RSTN = 1'b1;
    @(posedge CLK); #1;
    check("idle_after_reset", 32'(lines()), 32'h3);

    send_frame(8'hFF, 8'h8F, 1'b0, -1);
    send_frame(8'hC3, 8'hA5, 1'b0, -1);
    send_frame(8'hC4, 8'h3C, 1'b1, -1);
    send_frame(8'hFF, 8'h81, 1'b1, -1);
    send_frame(8'hC1, 8'h5A, 1'b0, 15);
    send_frame(8'hC2, 8'h96, 1'b0, -1);

    for (int i = 0; i < 16; i++) send_frame(8'hC0 + 8'(i), 8'($urandom), 1'b0, -1);

    for (int i = 0; i < 12; i++) begin
      p = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      send_frame(p, 8'($urandom), 1'($urandom_range(1)), -1);
    end

    @(posedge CLK); #1;
    check("quiet_idle", 32'(lines()), 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
